// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered one-hot grant and inter-grant gap
//
// Purpose:
//   Arbitrates N_REQ level-sensitive request lines in round-robin order and
//   drives a registered one-hot grant for a downstream one-hot encoder.
//   A one-cycle gap with gnt=0 is inserted after every release. This means the
//   encoder only ever sees all-zero or exactly one hot bit. The grant never
//   moves directly from one channel to another.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high, highest priority
//   req        in   N_REQ  level request per channel
//   gnt        out  N_REQ  registered one-hot grant, or all-zero
//   gnt_valid  out  1      high exactly when gnt != 0
//
// Parameters:
//   N_REQ     number of request channels (4, matches the encoder width)
//   MAX_HOLD  max consecutive grant cycles while others wait; 0 = unlimited

module rr_onehot_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid
);

  localparam int IW = $clog2(N_REQ);
  // The hold counter is kept at least one bit wide so MAX_HOLD=0 still elaborates.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             found;
  logic [IW-1:0]    pick;
  logic             competing;
  logic             release_now;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting at ptr_q. The loop runs from the farthest offset
  // down to offset 0, so the nearest requester overwrites the others and wins.
  // The index wraps naturally because IW bits cover exactly N_REQ channels.
  always_comb begin
    logic [IW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr_q + IW'(k);
      if (req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign competing = |(req & ~onehot(cur_q));

  // Forced release fires on the last allowed hold cycle, and only when
  // someone else is waiting. A lone requester keeps its grant forever.
  assign release_now = !req[cur_q] ||
                       ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && competing);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;

    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d   = onehot(pick);
          cur_d   = pick;
          hold_d  = '0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        hold_d = (hold_q == {HW{1'b1}}) ? hold_q : hold_q + HW'(1);
        if (release_now) begin
          gnt_d   = '0;
          ptr_d   = cur_q + IW'(1);
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        // ptr_q already points past the released channel. The released
        // channel is therefore reached last, so it wins only when it is the
        // sole requester.
        gnt_d = '0;
        if (found) begin
          gnt_d   = onehot(pick);
          cur_d   = pick;
          hold_d  = '0;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - directed self-checking bench for rr_onehot_arbiter

module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] prev_gnt = 4'b0000;

  rr_onehot_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Downstream 4-to-2 encoder model.
  function automatic logic [1:0] enc(input logic [3:0] g);
    if (g[3])      return 2'd3;
    else if (g[2]) return 2'd2;
    else if (g[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Every-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    n_cmp++;
    if (!(gnt == 4'b0000 || $countones(gnt) == 1)) begin
      n_bad++;
      $display("FAIL inv_onehot: gnt=%b required zero or one-hot", gnt);
    end
    n_cmp++;
    if (gnt_valid !== (|gnt)) begin
      n_bad++;
      $display("FAIL inv_valid: gnt_valid=%b required %b (gnt=%b)", gnt_valid, |gnt, gnt);
    end
    n_cmp++;
    if (prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt) begin
      n_bad++;
      $display("FAIL inv_no_direct_switch: gnt=%b prev=%b required a zero gap", gnt, prev_gnt);
    end
    prev_gnt <= gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: gnt=%b valid=%b required 0000/0", i, gnt, gnt_valid);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_grant: gnt=%b valid=%b required 0001/1", gnt, gnt_valid);
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0100) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: gnt=%b required 0100", i, gnt);
      end
    end
    n_cmp++;
    if (enc(gnt) !== 2'd2) begin
      n_bad++;
      $display("FAIL single_hold_enc: enc=%0d required 2", enc(gnt));
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_release: gnt=%b required 0000", gnt);
    end
  endtask

  task automatic test_rr_pattern();
    logic [3:0] exp;
    int         ch;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 72; c++) begin
      tick();
      ch  = (c / 9) % 4;
      exp = ((c % 9) < 8) ? (4'b0001 << ch) : 4'b0000;
      n_cmp++;
      if (gnt !== exp) begin
        n_bad++;
        $display("FAIL rr_pattern[%0d]: gnt=%b required %b", c, gnt, exp);
      end
      if (exp != 4'b0000) begin
        n_cmp++;
        if (enc(gnt) !== 2'(ch)) begin
          n_bad++;
          $display("FAIL rr_enc[%0d]: enc=%0d required %0d", c, enc(gnt), ch);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_bad++;
        $display("FAIL early_grant[%0d]: gnt=%b required 0010", i, gnt);
      end
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL early_drop: gnt=%b required 0000", gnt);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL early_next_ptr2: gnt=%b required 0100", gnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_bad++;
      $display("FAIL midrst_grant: gnt=%b required 1000", gnt);
    end
    rst = 1'b1;
    req = 4'b1111;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_clear: gnt=%b valid=%b required 0000/0", gnt, gnt_valid);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL midrst_ptr0: gnt=%b required 0001", gnt);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL wrap_idle: gnt=%b required 0000", gnt);
    end
    req = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp = (c < 8) ? 4'b1000 : ((c == 8) ? 4'b0000 : 4'b0001);
      n_cmp++;
      if (gnt !== exp) begin
        n_bad++;
        $display("FAIL wrap[%0d]: gnt=%b required %b", c, gnt, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] noise [4];
    noise[0] = 4'b1011;
    noise[1] = 4'b0101;
    noise[2] = 4'b1111;
    noise[3] = 4'b0011;
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      req = noise[i];
      tick();
      n_cmp++;
      if (gnt !== 4'b0001) begin
        n_bad++;
        $display("FAIL noise_ignored[%0d]: gnt=%b required 0001", i, gnt);
      end
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL b2b_gap: gnt=%b required 0000", gnt);
    end
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL b2b_sole_regrant: gnt=%b required 0001", gnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_single_hold();
    test_rr_pattern();
    test_early_release();
    test_reset_mid_grant();
    test_wrap();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
